// File: rtl/mcntrl_page_sequencer.sv
// Per-channel frame/page sequencer for a read channel: requests one frame line at a time
// from the memory scheduler into a NUM_PAGES-deep page buffer and tracks frame progress.
module mcntrl_page_sequencer #(
  parameter int FRAME_HEIGHT_BITS = 16,
  parameter int ADDR_BITS         = 22,
  parameter int NUM_PAGES         = 4
) (
  input  logic                         mclk,
  input  logic                         rst_n,
  input  logic [FRAME_HEIGHT_BITS-1:0] frame_height,
  input  logic [ADDR_BITS-1:0]         start_addr,
  input  logic [ADDR_BITS-1:0]         line_stride,
  input  logic                         frame_start,
  input  logic                         next_page,
  input  logic                         suspend,
  output logic                         page_ready,
  output logic                         frame_done,
  output logic [FRAME_HEIGHT_BITS-1:0] line_unfinished,
  output logic                         busy,
  output logic                         xfer_want,
  input  logic                         xfer_grant,
  output logic [ADDR_BITS-1:0]         xfer_addr,
  input  logic                         xfer_done,
  output logic                         cmd_err,
  output logic                         buf_underflow
);

  localparam int CNT_BITS = $clog2(NUM_PAGES + 1);
  localparam logic [CNT_BITS-1:0]          PAGES     = CNT_BITS'(NUM_PAGES);
  localparam logic [CNT_BITS-1:0]          CNT_ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0]          CNT_ZERO  = CNT_BITS'(0);
  localparam logic [FRAME_HEIGHT_BITS-1:0] LINE_ONE  = FRAME_HEIGHT_BITS'(1);
  localparam logic [FRAME_HEIGHT_BITS-1:0] LINE_ZERO = FRAME_HEIGHT_BITS'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    REQ  = 2'd2,
    XFER = 2'd3
  } state_t;

  state_t                         state;
  state_t                         next_state;
  logic [FRAME_HEIGHT_BITS-1:0]   lines_issued;
  logic [FRAME_HEIGHT_BITS-1:0]   lines_done;
  logic [FRAME_HEIGHT_BITS-1:0]   height;
  logic [ADDR_BITS-1:0]           addr_acc;
  logic [CNT_BITS-1:0]            buf_cnt;
  logic                           start_ok;
  logic                           zero_frame;
  logic                           grant_ok;
  logic                           done_ok;
  logic                           last_line;
  logic                           can_issue;
  logic                           want_nxt;
  logic                           busy_nxt;
  logic                           page_ready_nxt;
  logic                           frame_done_nxt;

  assign start_ok        = frame_start && (state == IDLE);
  assign zero_frame      = start_ok && (frame_height == LINE_ZERO);
  assign grant_ok        = xfer_grant && (state == REQ);
  assign done_ok         = xfer_done && (state == XFER);
  assign last_line       = ((lines_done + LINE_ONE) == height);
  assign can_issue       = !suspend && (buf_cnt < PAGES) && (lines_issued < height);
  assign line_unfinished = lines_done;

  // State register.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a grant wins over a simultaneous suspend.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_ok && !zero_frame) next_state = WAIT;
        else                         next_state = IDLE;
      end
      WAIT: begin
        if (can_issue) next_state = REQ;
        else           next_state = WAIT;
      end
      REQ: begin
        if (xfer_grant)   next_state = XFER;
        else if (suspend) next_state = WAIT;
        else              next_state = REQ;
      end
      XFER: begin
        if (xfer_done && last_line) next_state = IDLE;
        else if (xfer_done)         next_state = WAIT;
        else                        next_state = XFER;
      end
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered handshake outputs.
  always_comb begin
    want_nxt       = (next_state == REQ);
    busy_nxt       = (next_state != IDLE);
    page_ready_nxt = done_ok;
    frame_done_nxt = zero_frame || (done_ok && last_line);
  end

  // Counters, address accumulator, buffer occupancy and registered outputs.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_want     <= 1'b0;
      busy          <= 1'b0;
      page_ready    <= 1'b0;
      frame_done    <= 1'b0;
      xfer_addr     <= '0;
      cmd_err       <= 1'b0;
      buf_underflow <= 1'b0;
      lines_issued  <= '0;
      lines_done    <= '0;
      height        <= '0;
      addr_acc      <= '0;
      buf_cnt       <= '0;
    end else begin
      xfer_want  <= want_nxt;
      busy       <= busy_nxt;
      page_ready <= page_ready_nxt;
      frame_done <= frame_done_nxt;
      cmd_err    <= cmd_err | (frame_start && (state != IDLE));

      if (start_ok) begin
        height       <= frame_height;
        lines_issued <= LINE_ZERO;
        lines_done   <= LINE_ZERO;
        addr_acc     <= start_addr;
      end else begin
        if (grant_ok) begin
          lines_issued <= lines_issued + LINE_ONE;
          addr_acc     <= addr_acc + line_stride;
        end
        if (done_ok) begin
          lines_done <= lines_done + LINE_ONE;
        end
      end

      // addr_acc only moves on the grant that leaves REQ, so this holds through XFER.
      if (next_state == REQ) begin
        xfer_addr <= addr_acc;
      end

      case ({done_ok, next_page})
        2'b10: buf_cnt <= buf_cnt + CNT_ONE;
        2'b01: begin
          if (buf_cnt != CNT_ZERO) begin
            buf_cnt <= buf_cnt - CNT_ONE;
          end else begin
            buf_underflow <= 1'b1;
          end
        end
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_mcntrl_page_sequencer.sv
// Self-checking bench for mcntrl_page_sequencer: expected line addresses are queued when a
// frame is started and popped as each grant is issued.
module tb_mcntrl_page_sequencer;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] frame_height = 16'd0;
  logic [21:0] start_addr = 22'd0;
  logic [21:0] line_stride = 22'd0;
  logic        frame_start = 1'b0;
  logic        next_page = 1'b0;
  logic        suspend = 1'b0;
  logic        page_ready;
  logic        frame_done;
  logic [15:0] line_unfinished;
  logic        busy;
  logic        xfer_want;
  logic        xfer_grant = 1'b0;
  logic [21:0] xfer_addr;
  logic        xfer_done = 1'b0;
  logic        cmd_err;
  logic        buf_underflow;

  int checks = 0;
  int errors = 0;
  logic [21:0] exp_addr_q[$];

  mcntrl_page_sequencer #(
    .FRAME_HEIGHT_BITS(16),
    .ADDR_BITS(22),
    .NUM_PAGES(4)
  ) dut (
    .mclk(mclk), .rst_n(rst_n), .frame_height(frame_height), .start_addr(start_addr),
    .line_stride(line_stride), .frame_start(frame_start), .next_page(next_page),
    .suspend(suspend), .page_ready(page_ready), .frame_done(frame_done),
    .line_unfinished(line_unfinished), .busy(busy), .xfer_want(xfer_want),
    .xfer_grant(xfer_grant), .xfer_addr(xfer_addr), .xfer_done(xfer_done),
    .cmd_err(cmd_err), .buf_underflow(buf_underflow)
  );

  always #5 mclk = ~mclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic pulse_next_page();
    next_page = 1'b1;
    step();
    next_page = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] h, input logic [21:0] a, input logic [21:0] s);
    logic [21:0] addr;
    addr = a;
    for (int i = 0; i < int'(h); i++) begin
      exp_addr_q.push_back(addr);
      addr = addr + s;
    end
    frame_height = h;
    start_addr   = a;
    line_stride  = s;
    frame_start  = 1'b1;
    step();
    frame_start  = 1'b0;
  endtask

  task automatic wait_want(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (xfer_want === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Grants the pending request and completes it one cycle later; returns what was seen.
  task automatic grant_done(output logic [21:0] addr, output logic pr, output logic fd,
                            output logic want_g1);
    addr       = xfer_addr;
    xfer_grant = 1'b1;
    step();
    xfer_grant = 1'b0;
    want_g1    = xfer_want;
    xfer_done  = 1'b1;
    step();
    xfer_done  = 1'b0;
    pr         = page_ready;
    fd         = frame_done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({xfer_want, busy, page_ready, frame_done, cmd_err, buf_underflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {xfer_want, busy, page_ready, frame_done, cmd_err, buf_underflow});
    end
    checks++;
    if (line_unfinished !== 16'd0) begin
      errors++;
      $display("FAIL reset_line_unfinished: got %0d expected 0", line_unfinished);
    end
    checks++;
    if (xfer_addr !== 22'd0) begin
      errors++;
      $display("FAIL reset_xfer_addr: got %h expected 0", xfer_addr);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    logic [21:0] a;
    logic [21:0] e;
    logic pr, fd, w1;
    start_frame(16'd3, 22'h000100, 22'h000020);
    checks++;
    if (busy !== 1'b1 || xfer_want !== 1'b0) begin
      errors++;
      $display("FAIL basic_t1: busy=%b want=%b expected busy=1 want=0", busy, xfer_want);
    end
    step();
    checks++;
    if (xfer_want !== 1'b1) begin
      errors++;
      $display("FAIL basic_t2_want: got %b expected 1", xfer_want);
    end
    for (int i = 0; i < 3; i++) begin
      wait_want(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL basic_want_timeout: line %0d xfer_want=%b expected 1", i, xfer_want);
      end
      e = exp_addr_q.pop_front();
      grant_done(a, pr, fd, w1);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL basic_addr: line %0d got %h expected %h", i, a, e);
      end
      checks++;
      if (w1 !== 1'b0 || pr !== 1'b1) begin
        errors++;
        $display("FAIL basic_handshake: line %0d want_g1=%b page_ready=%b expected 0 1", i, w1, pr);
      end
      checks++;
      if (fd !== (i == 2)) begin
        errors++;
        $display("FAIL basic_frame_done: line %0d got %b expected %b", i, fd, (i == 2));
      end
      checks++;
      if (line_unfinished !== 16'(i + 1)) begin
        errors++;
        $display("FAIL basic_line_unfinished: got %0d expected %0d", line_unfinished, i + 1);
      end
      if (i == 2) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL basic_busy_end: got %b expected 0", busy);
        end
      end
      pulse_next_page();
    end
  endtask

  task automatic test_full_buffer();
    bit ok;
    int hi;
    logic [21:0] a;
    logic [21:0] e;
    logic pr, fd, w1;
    start_frame(16'd6, 22'h000400, 22'h000040);
    for (int i = 0; i < 4; i++) begin
      wait_want(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL full_want_timeout: line %0d xfer_want=%b expected 1", i, xfer_want);
      end
      e = exp_addr_q.pop_front();
      grant_done(a, pr, fd, w1);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL full_addr: line %0d got %h expected %h", i, a, e);
      end
    end
    hi = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (xfer_want !== 1'b0) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL full_no_request: xfer_want high %0d cycles expected 0", hi);
    end
    next_page = 1'b1;
    step();
    next_page = 1'b0;
    checks++;
    if (xfer_want !== 1'b0) begin
      errors++;
      $display("FAIL full_n1_want: got %b expected 0", xfer_want);
    end
    step();
    checks++;
    if (xfer_want !== 1'b1) begin
      errors++;
      $display("FAIL full_n2_want: got %b expected 1", xfer_want);
    end
    e = exp_addr_q.pop_front();
    grant_done(a, pr, fd, w1);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL full_addr5: got %h expected %h", a, e);
    end
    pulse_next_page();
    wait_want(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_want6_timeout: xfer_want=%b expected 1", xfer_want);
    end
    e = exp_addr_q.pop_front();
    grant_done(a, pr, fd, w1);
    checks++;
    if (a !== e || fd !== 1'b1) begin
      errors++;
      $display("FAIL full_last: addr=%h frame_done=%b expected %h 1", a, fd, e);
    end
    repeat (4) pulse_next_page();
    checks++;
    if (buf_underflow !== 1'b0) begin
      errors++;
      $display("FAIL full_drain_underflow: got %b expected 0", buf_underflow);
    end
  endtask

  task automatic test_suspend();
    bit ok;
    int hi;
    logic [21:0] a;
    logic [21:0] e;
    logic pr, fd, w1;
    start_frame(16'd2, 22'h000200, 22'h000010);
    wait_want(ok);
    e = exp_addr_q.pop_front();
    grant_done(a, pr, fd, w1);
    checks++;
    if (!ok || a !== e) begin
      errors++;
      $display("FAIL suspend_line0: ok=%b addr=%h expected 1 %h", ok, a, e);
    end
    pulse_next_page();
    wait_want(ok);
    suspend = 1'b1;
    step();
    checks++;
    if (!ok || xfer_want !== 1'b0) begin
      errors++;
      $display("FAIL suspend_drop: ok=%b xfer_want=%b expected 1 0", ok, xfer_want);
    end
    xfer_grant = 1'b1;
    step();
    xfer_grant = 1'b0;
    hi = 0;
    for (int c = 0; c < 3; c++) begin
      if (xfer_want !== 1'b0) hi++;
      step();
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL suspend_hold: xfer_want high %0d cycles expected 0", hi);
    end
    suspend = 1'b0;
    wait_want(ok);
    e = exp_addr_q.pop_front();
    checks++;
    if (!ok || xfer_addr !== e) begin
      errors++;
      $display("FAIL suspend_resume_addr: ok=%b addr=%h expected 1 %h", ok, xfer_addr, e);
    end
    grant_done(a, pr, fd, w1);
    checks++;
    if (fd !== 1'b1 || line_unfinished !== 16'd2) begin
      errors++;
      $display("FAIL suspend_end: frame_done=%b line_unfinished=%0d expected 1 2", fd, line_unfinished);
    end
    pulse_next_page();
  endtask

  task automatic test_wrap();
    bit ok;
    logic [21:0] a;
    logic [21:0] e;
    logic pr, fd, w1;
    start_frame(16'd2, 22'h3FFFF0, 22'h000020);
    for (int i = 0; i < 2; i++) begin
      wait_want(ok);
      e = exp_addr_q.pop_front();
      grant_done(a, pr, fd, w1);
      checks++;
      if (!ok || a !== e) begin
        errors++;
        $display("FAIL wrap_addr: line %0d ok=%b got %h expected %h", i, ok, a, e);
      end
    end
    checks++;
    if (a !== 22'h000010) begin
      errors++;
      $display("FAIL wrap_second: got %h expected 000010", a);
    end
    repeat (2) pulse_next_page();
  endtask

  task automatic test_zero_height();
    int hi;
    start_frame(16'd0, 22'h000300, 22'h000010);
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_t1: frame_done=%b busy=%b expected 1 0", frame_done, busy);
    end
    hi = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (xfer_want !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) hi++;
    end
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL zero_quiet: %0d active cycles expected 0", hi);
    end
  endtask

  task automatic test_cmd_err();
    bit ok;
    logic [21:0] a;
    logic [21:0] e;
    start_frame(16'd1, 22'h000500, 22'h000010);
    wait_want(ok);
    e = exp_addr_q.pop_front();
    a = xfer_addr;
    xfer_grant = 1'b1;
    step();
    xfer_grant   = 1'b0;
    frame_height = 16'd5;
    start_addr   = 22'h000000;
    frame_start  = 1'b1;
    step();
    frame_start  = 1'b0;
    checks++;
    if (cmd_err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cmd_err_set: cmd_err=%b busy=%b expected 1 1", cmd_err, busy);
    end
    checks++;
    if (!ok || xfer_addr !== e || a !== e) begin
      errors++;
      $display("FAIL cmd_err_addr: ok=%b addr=%h expected %h", ok, xfer_addr, e);
    end
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    checks++;
    if (page_ready !== 1'b1 || frame_done !== 1'b1 || line_unfinished !== 16'd1) begin
      errors++;
      $display("FAIL cmd_err_frame: page_ready=%b frame_done=%b line_unfinished=%0d expected 1 1 1",
               page_ready, frame_done, line_unfinished);
    end
    pulse_next_page();
  endtask

  task automatic test_same_cycle();
    bit ok;
    logic [21:0] a;
    logic [21:0] e;
    logic pr, fd, w1;
    start_frame(16'd4, 22'h000600, 22'h000008);
    for (int i = 0; i < 2; i++) begin
      wait_want(ok);
      e = exp_addr_q.pop_front();
      grant_done(a, pr, fd, w1);
      checks++;
      if (!ok || a !== e) begin
        errors++;
        $display("FAIL same_addr: line %0d ok=%b got %h expected %h", i, ok, a, e);
      end
    end
    wait_want(ok);
    e = exp_addr_q.pop_front();
    checks++;
    if (!ok || xfer_addr !== e) begin
      errors++;
      $display("FAIL same_addr2: ok=%b got %h expected %h", ok, xfer_addr, e);
    end
    xfer_grant = 1'b1;
    step();
    xfer_grant = 1'b0;
    xfer_done  = 1'b1;
    next_page  = 1'b1;
    step();
    xfer_done  = 1'b0;
    next_page  = 1'b0;
    checks++;
    if (page_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_page_ready: got %b expected 1", page_ready);
    end
    wait_want(ok);
    e = exp_addr_q.pop_front();
    grant_done(a, pr, fd, w1);
    checks++;
    if (!ok || a !== e || fd !== 1'b1) begin
      errors++;
      $display("FAIL same_last: ok=%b addr=%h frame_done=%b expected %h 1", ok, a, fd, e);
    end
    repeat (3) pulse_next_page();
    checks++;
    if (buf_underflow !== 1'b0) begin
      errors++;
      $display("FAIL same_buf_count: underflow=%b expected 0 after 3 releases", buf_underflow);
    end
    pulse_next_page();
    checks++;
    if (buf_underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow_set: got %b expected 1", buf_underflow);
    end
  endtask

  task automatic test_reset_mid_xfer();
    bit ok;
    exp_addr_q.delete();
    start_frame(16'd3, 22'h000700, 22'h000010);
    wait_want(ok);
    xfer_grant = 1'b1;
    step();
    xfer_grant = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({xfer_want, busy, page_ready, frame_done, cmd_err, buf_underflow} !== 6'b0 ||
        line_unfinished !== 16'd0 || xfer_addr !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b line=%0d addr=%h expected 0 0 0",
               {xfer_want, busy, page_ready, frame_done, cmd_err, buf_underflow},
               line_unfinished, xfer_addr);
    end
    step();
    rst_n = 1'b1;
    step();
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    checks++;
    if (page_ready !== 1'b0 || busy !== 1'b0 || ok !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_idle: page_ready=%b busy=%b expected 0 0", page_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_buffer();
    test_suspend();
    test_wrap();
    test_zero_height();
    test_cmd_err();
    test_same_cycle();
    test_reset_mid_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
